// File: rtl/ntcrack_host_link.sv
// Host-side controller for the cracker core's byte-serial port: serialises
// 128-bit target hashes into strobed bytes and reassembles 20-byte passwords.
module ntcrack_host_link #(
  parameter int unsigned STROBE_GAP  = 3,
  parameter int unsigned HASH_SETTLE = 32,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [127:0]     hash_in,
  input  logic             hash_valid,
  output logic             hash_ready,
  input  logic             start,
  output logic [7:0]       new_hash_byte,
  output logic             store_hash_byte,
  output logic             go,
  input  logic             match_found,
  input  logic [7:0]       password_byte,
  output logic [159:0]     pw_chars,
  output logic             pw_valid,
  input  logic             pw_ready,
  output logic [4:0]       hash_count,
  output logic [CNT_W-1:0] match_count,
  output logic             cracking
);

  localparam int unsigned TMAX     = (HASH_SETTLE > STROBE_GAP) ? HASH_SETTLE : STROBE_GAP;
  localparam int unsigned TW       = $clog2(TMAX + 1);
  localparam int unsigned PW_BYTES = 20;

  typedef enum logic [3:0] {
    S_IDLE,
    S_STROBE,
    S_GAP,
    S_SETTLE,
    S_GO,
    S_LISTEN,
    S_CAPTURE,
    S_ACK,
    S_DROP,
    S_REPORT
  } state_t;

  state_t state, state_next;

  logic [TW-1:0]  timer;
  logic [3:0]     byte_idx;
  logic [4:0]     pw_idx;
  logic [127:0]   hash_sh;
  logic [7:0]     byte_q;
  logic [159:0]   pw_sh;
  logic           gap_done;
  logic           settle_done;
  logic           last_byte;
  logic           last_pw;
  logic           accept;
  logic           crack_req;

  assign gap_done    = (timer == TW'(STROBE_GAP - 1));
  assign settle_done = (timer == TW'(HASH_SETTLE - 1));
  assign last_byte   = (byte_idx == 4'd15);
  assign last_pw     = (pw_idx == 5'(PW_BYTES - 1));
  assign accept      = hash_valid && hash_ready;
  assign crack_req   = start && (hash_count != '0) && !cracking;
  assign pw_chars    = pw_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_STROBE;
        end else if (crack_req) begin
          state_next = S_GO;
        end
      end
      S_STROBE:  state_next = last_byte ? S_SETTLE : S_GAP;
      S_GAP:     if (gap_done) state_next = S_STROBE;
      S_SETTLE:  if (settle_done) state_next = S_IDLE;
      S_GO:      state_next = S_LISTEN;
      S_LISTEN:  if (match_found) state_next = S_CAPTURE;
      S_CAPTURE: state_next = last_pw ? S_REPORT : S_ACK;
      S_ACK:     state_next = S_DROP;
      S_DROP:    if (!match_found) state_next = S_LISTEN;
      S_REPORT:  if (pw_ready) state_next = S_ACK;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    store_hash_byte = (state == S_STROBE);
    go              = (state == S_GO) || (state == S_ACK);
    new_hash_byte   = (state == S_STROBE) ? hash_sh[127:120] : byte_q;
  end

  // hash_ready is registered from the next state so it reads 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_ready  <= 1'b0;
      timer       <= '0;
      byte_idx    <= '0;
      pw_idx      <= '0;
      hash_sh     <= '0;
      byte_q      <= '0;
      pw_sh       <= '0;
      pw_valid    <= 1'b0;
      hash_count  <= '0;
      match_count <= '0;
      cracking    <= 1'b0;
    end else begin
      hash_ready <= (state_next == S_IDLE) && !cracking;
      timer      <= ((state == S_GAP || state == S_SETTLE) && state_next == state)
                    ? timer + 1'b1 : '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            hash_sh  <= hash_in;
            byte_idx <= '0;
          end
        end
        S_STROBE: begin
          byte_q   <= hash_sh[127:120];
          hash_sh  <= {hash_sh[119:0], 8'h00};
          byte_idx <= byte_idx + 1'b1;
        end
        S_SETTLE: begin
          if (settle_done && hash_count != 5'd31) begin
            hash_count <= hash_count + 1'b1;
          end
        end
        S_GO: cracking <= 1'b1;
        S_CAPTURE: begin
          pw_sh <= {pw_sh[151:0], password_byte};
          if (last_pw) begin
            pw_valid <= 1'b1;
          end
        end
        // The deferred 20th ack passes through here too; it wraps the slot index.
        S_ACK: pw_idx <= last_pw ? '0 : pw_idx + 1'b1;
        S_REPORT: begin
          if (pw_ready) begin
            pw_valid <= 1'b0;
            if (match_count != '1) begin
              match_count <= match_count + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  a_go_store_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(go && store_hash_byte));
  a_go_single: assert property (@(posedge clk) disable iff (!rst_n)
    !(go && $past(go)));

endmodule

// File: tb/tb_ntcrack_host_link.sv
// Bench for ntcrack_host_link: table-driven hash loads, core model for
// password readback, scoreboards for strobed bytes and delivered passwords.
module tb_ntcrack_host_link;

  localparam int unsigned STROBE_GAP  = 3;
  localparam int unsigned HASH_SETTLE = 32;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned LOAD_LAT    = 1 + 15 * (STROBE_GAP + 1) + HASH_SETTLE + 1;

  logic             clk;
  logic             rst_n;
  logic [127:0]     hash_in;
  logic             hash_valid;
  logic             hash_ready;
  logic             start;
  logic [7:0]       new_hash_byte;
  logic             store_hash_byte;
  logic             go;
  logic             match_found;
  logic [7:0]       password_byte;
  logic [159:0]     pw_chars;
  logic             pw_valid;
  logic             pw_ready;
  logic [4:0]       hash_count;
  logic [CNT_W-1:0] match_count;
  logic             cracking;

  ntcrack_host_link #(
    .STROBE_GAP (STROBE_GAP),
    .HASH_SETTLE(HASH_SETTLE),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hash_in        (hash_in),
    .hash_valid     (hash_valid),
    .hash_ready     (hash_ready),
    .start          (start),
    .new_hash_byte  (new_hash_byte),
    .store_hash_byte(store_hash_byte),
    .go             (go),
    .match_found    (match_found),
    .password_byte  (password_byte),
    .pw_chars       (pw_chars),
    .pw_valid       (pw_valid),
    .pw_ready       (pw_ready),
    .hash_count     (hash_count),
    .match_count    (match_count),
    .cracking       (cracking)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          go_count = 0;
  logic        prev_go = 1'b0;
  int unsigned last_strobe = 0;
  int          sb_pos = 0;
  logic [7:0]   exp_bytes[$];
  logic [159:0] exp_pw[$];

  typedef struct {
    logic [127:0] hash;
    logic         with_start;
    logic [4:0]   exp_count;
  } hvec_t;

  hvec_t vecs[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {hash_ready, store_hash_byte, go, new_hash_byte, pw_valid,
                 cracking, hash_count, match_count}, '0);
    check({name, "_pw_chars"}, pw_chars, '0);
  endtask

  // Strobe/go monitor and both scoreboards' pop side.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_pos  = 0;
      prev_go = 1'b0;
    end else begin
      if (store_hash_byte) begin
        check("strobe_not_with_go", go, 1'b0);
        if (sb_pos != 0) check("strobe_spacing", cyc - last_strobe, STROBE_GAP + 1);
        last_strobe = cyc;
        sb_pos = (sb_pos + 1) % 16;
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got byte %0h expected no strobe", new_hash_byte);
        end else begin
          check("strobe_byte", new_hash_byte, exp_bytes.pop_front());
        end
      end
      if (go) begin
        go_count++;
        check("go_width", prev_go, 1'b0);
      end
      prev_go = go;
      if (pw_valid && pw_ready) begin
        if (exp_pw.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pw: got %0h expected no password", pw_chars);
        end else begin
          check("pw_chars", pw_chars, exp_pw.pop_front());
        end
      end
    end
  end

  task automatic load_hash(input logic [127:0] h, input logic with_start, input logic [4:0] exp_count);
    int n;
    logic [127:0] t;
    @(negedge clk);
    check("load_ready_before", hash_ready, 1'b1);
    t = h;
    for (int k = 0; k < 16; k++) begin
      exp_bytes.push_back(t[127:120]);
      t = t << 8;
    end
    hash_in    = h;
    hash_valid = 1'b1;
    start      = with_start;
    @(posedge clk);
    #1 hash_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n = 1;
    while (!hash_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("load_latency", n, LOAD_LAT);
    check("load_bytes_left", exp_bytes.size(), 0);
    check("hash_count", hash_count, exp_count);
  endtask

  // Core model: each byte held on match_found until go, dropped on the go edge.
  task automatic send_password(input logic [159:0] pw, input int hold);
    int n;
    int g0;
    logic [159:0] t;
    logic [159:0] snap;
    logic stable;
    exp_pw.push_back(pw);
    t  = pw;
    g0 = go_count;
    for (int k = 0; k < 20; k++) begin
      repeat (3) @(negedge clk);
      password_byte = t[159:152];
      t = t << 8;
      match_found = 1'b1;
      if (k == 19) begin
        n = 0;
        while (!pw_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("acks_before_report", go_count - g0, 19);
        check("pw_valid_raised", pw_valid, 1'b1);
        check("pw_head", pw_chars[159:128], pw[159:128]);
        snap   = pw_chars;
        stable = 1'b1;
        for (int c = 0; c < hold; c++) begin
          @(negedge clk);
          if (!pw_valid || pw_chars !== snap || go) stable = 1'b0;
        end
        if (hold > 0) check("report_hold_stable", stable, 1'b1);
        @(posedge clk);
        #1 pw_ready = 1'b1;
        @(posedge clk);
        #1 pw_ready = 1'b0;
        check("final_go", go, 1'b1);
        check("pw_valid_cleared", pw_valid, 1'b0);
        @(posedge clk);
        #1 match_found = 1'b0;
        #4 check("final_go_width", go, 1'b0);
      end else begin
        n = 0;
        while (!go && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("ack_go_seen", go, 1'b1);
        @(posedge clk);
        #1 match_found = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    check("acks_total", go_count - g0, 20);
  endtask

  initial begin
    int n;
    int k;
    int g0;
    logic [127:0] t;
    logic [159:0] pw1;
    logic [159:0] pw2;

    vecs[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 5'd1};
    vecs[1] = '{128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 1'b1, 5'd2};
    vecs[2] = '{128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0, 5'd3};
    pw1 = {32'h70617373, {16{8'h20}}};
    pw2 = {$urandom, $urandom, $urandom, $urandom, $urandom};

    rst_n         = 1'b1;
    hash_in       = '0;
    hash_valid    = 1'b0;
    start         = 1'b0;
    match_found   = 1'b0;
    password_byte = '0;
    pw_ready      = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_values");
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("idle_hash_ready", hash_ready, 1'b1);

    // start with no hash loaded is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("start_ignored_go", go_count, 0);
    check("start_ignored_cracking", cracking, 1'b0);

    // reset after the 7th strobe of a load
    @(negedge clk);
    hash_in = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    t = hash_in;
    for (int j = 0; j < 16; j++) begin
      exp_bytes.push_back(t[127:120]);
      t = t << 8;
    end
    hash_valid = 1'b1;
    @(posedge clk);
    #1 hash_valid = 1'b0;
    n = 0;
    k = 0;
    while (k < 7 && n < 100) begin
      @(negedge clk);
      n++;
      if (store_hash_byte) k++;
    end
    check("partial_strobes", k, 7);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("mid_load_reset");
    exp_bytes.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      load_hash(vecs[i].hash, vecs[i].with_start, vecs[i].exp_count);
    end
    check("no_go_during_loads", go_count, 0);
    check("not_cracking_yet", cracking, 1'b0);

    // start cracking
    @(negedge clk);
    g0 = go_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("go_pulse", go, 1'b1);
    @(negedge clk);
    check("go_one_cycle", go, 1'b0);
    check("cracking_set", cracking, 1'b1);
    check("hash_ready_after_go", hash_ready, 1'b0);
    hash_in    = 128'h11111111_22222222_33333333_44444444;
    hash_valid = 1'b1;
    repeat (20) @(negedge clk);
    check("hash_rejected_ready", hash_ready, 1'b0);
    check("hash_rejected_count", hash_count, 5'd3);
    hash_valid = 1'b0;
    check("single_start_go", go_count - g0, 1);

    send_password(pw1, 0);
    check("match_count_1", match_count, 16'd1);
    send_password(pw2, 50);
    check("match_count_2", match_count, 16'd2);
    check("pw_queue_drained", exp_pw.size(), 0);
    check("still_cracking", cracking, 1'b1);
    check("hash_ready_stuck", hash_ready, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ntcrack_host_link.md
Name: ntcrack_host_link

Overview:
- Host-side controller for the cracker core's byte-serial interface: the other end of that core's protocol.
- Load side: accepts 128-bit target hashes on a valid/ready port and serialises each into 16 strobed bytes on new_hash_byte/store_hash_byte, then issues the single go that starts cracking.
- Readback side: collects the 20 password bytes the core emits per match (match_found/password_byte, acked with go) and presents each cracked password as one 160-bit word on a valid/ready port.

Parameters:
- STROBE_GAP, 3: idle cycles between consecutive store_hash_byte pulses; legal range is ≥2, because the core occupies 3 cycles per byte.
- HASH_SETTLE, 32: idle cycles after a hash's 16th strobe before the next hash or go; covers the core's checker store.
- CNT_W, 16: width of the match counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- hash_in  in  128  target hash; byte k is hash_in[127-8k -: 8]
- hash_valid  in  1  hash_in is valid
- hash_ready  out  1  hash accepted on hash_valid&&hash_ready
- start  in  1  one-cycle request to begin cracking
- new_hash_byte  out  8  hash byte to the core
- store_hash_byte  out  1  one-cycle strobe to the core
- go  out  1  start pulse / per-byte readback ack to the core
- match_found  in  1  core has a password byte ready
- password_byte  in  8  password byte from the core
- pw_chars  out  160  cracked password; byte k is pw_chars[159-8k -: 8]
- pw_valid  out  1  pw_chars is valid
- pw_ready  in  1  consumer accepts pw_chars
- hash_count  out  5  hashes loaded, saturating at 31
- match_count  out  CNT_W  passwords delivered, saturating
- cracking  out  1  go has been issued

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: every output and all state are 0, FSM in IDLE.
- Reset mid-operation aborts immediately. A partial hash load is lost, and the core must be reset alongside this block.
- IDLE:
  - hash_ready = !cracking.
  - On hash_valid&&hash_ready: latch hash_in, byte index b=0, go to STROBE.
  - Else if start && hash_count≠0 && !cracking: go to GO.
  - If both occur in the same cycle, the hash wins and start is dropped; start is a pulse and is not remembered.
  - start with hash_count==0 is ignored.
- STROBE: 1 cycle. new_hash_byte = latched byte b; store_hash_byte=1.
  - If b==15, go to SETTLE. Otherwise go to GAP.
- GAP: exactly STROBE_GAP cycles with store_hash_byte=0, then b++ and go to STROBE.
  - new_hash_byte holds its last value outside STROBE.
- SETTLE: HASH_SETTLE cycles, then hash_count++ (saturating) and return to IDLE.
- GO: go=1 for exactly 1 cycle; cracking←1 (sticky until reset). Then go to LISTEN.
  - hash_ready stays 0 for ever after this point; the core never returns to its load stage.
- LISTEN: wait for match_found=1, then go to CAPTURE.
- CAPTURE: 1 cycle. Write password_byte into pw_chars slot p, where p is 0..19 and resets to 0 after delivery.
  - If p<19, go to ACK. Otherwise raise pw_valid and go to REPORT.
- ACK: go=1 for 1 cycle, p++, then go to DROP.
- DROP: wait for match_found=0, then go to LISTEN.
  - The core drops match_found on the edge it samples go.
  - The next byte is raised ≥3 cycles later.
- REPORT: hold pw_valid and pw_chars stable until pw_ready. Then:
  - pw_valid←0 and match_count++ (saturating);
  - the final (20th) go is deferred until this handshake and is issued through ACK;
  - p←0.
  - Consequence: pw_ready backpressure stalls the core.
  - pw_ready while pw_valid=0 is ignored.
- Pulse widths: go and store_hash_byte are never high for 2 consecutive cycles, and never high together.
- Unexpected input: match_found high while not cracking, or outside LISTEN, is ignored.

Test Plan:
1. Load hash 0x00112233_44556677_8899AABB_CCDDEEFF -> 16 single-cycle strobes carrying 00,11,…,FF in order, spaced STROBE_GAP+1 cycles; hash_ready returns 1 after HASH_SETTLE cycles; hash_count=1.
2. start with hash_count=0 -> no go; then load one hash and pulse start -> exactly one 1-cycle go; cracking=1; hash_ready stuck at 0; a later hash_valid is not accepted.
3. Core model emits "pass" followed by 16 bytes of 0x20, each byte held until go -> 19 ack pulses; pw_valid with pw_chars[159:128]=0x70617373; after pw_ready, the 20th go; match_count=1.
4. Hold pw_ready=0 for 50 cycles at REPORT -> pw_valid and pw_chars stable and no 20th go; release -> single go on the following cycle path, then LISTEN.
5. Assert rst_n=0 after the 7th strobe -> all outputs 0 immediately; reload a full hash -> first strobe carries byte 0 and hash_count=1.
6. hash_valid and start asserted in the same IDLE cycle with hash_count=1 -> hash load proceeds, no go; hash_count=2 afterwards.
